ascii_display_encoder: RTL and testbench

//  Responder side of the display-update start/valid handshake issued by the cycling-computer control FSM.
//  On each start request, it samples the mode flags and the selected measurement.
//  It then converts the value to BCD with a sequential shift-add-3 engine and returns six ASCII characters:
//  4 lower digits (selected quantity) and 2 upper digits (current speed), together with a one-cycle valid_out.

---
 rtl/ascii_display_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_ascii_display_encoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ascii_display_encoder.sv
// Display-update responder: samples the selected measurement on start, converts it
// to BCD with a sequential shift-add-3 engine and returns six ASCII characters.
module ascii_display_encoder #(
    parameter int unsigned SPEED_WIDTH     = 12,
    parameter int unsigned MAX_SPEED_WIDTH = 12,
    parameter int unsigned AVG_SPEED_WIDTH = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       AVS,
    input  logic                       DAY,
    input  logic                       MAX,
    input  logic                       TIM,
    input  logic [MAX_SPEED_WIDTH-1:0] max_speed,
    input  logic [SPEED_WIDTH-1:0]     speed,
    input  logic [13:0]                distance,
    input  logic [AVG_SPEED_WIDTH-1:0] avg_speed,
    input  logic [6:0]                 hours,
    input  logic [5:0]                 minutes,
    input  logic [5:0]                 seconds,
    output logic [7:0]                 lower1000,
    output logic [7:0]                 lower0100,
    output logic [7:0]                 lower0010,
    output logic [7:0]                 lower0001,
    output logic [7:0]                 upper10,
    output logic [7:0]                 upper01,
    output logic                       valid_out,
    output logic                       busy
);

    localparam int unsigned OP_W       = 14;
    localparam int unsigned BCD_LO_W   = 16;
    localparam int unsigned BCD_UP_W   = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned NUM_SHIFTS = 14;
    localparam logic [7:0]  ASCII_BLANK = 8'h20;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;

    typedef enum logic { ST_IDLE, ST_SHIFT } state_t;
    typedef enum logic [1:0] { SEL_DAY, SEL_AVS, SEL_MAX, SEL_TIM } sel_t;

    state_t               state_q, state_d;
    sel_t                 sel_q, sel_d, sel_new;
    logic [OP_W-1:0]      lo_bin_q, lo_bin_d, up_bin_q, up_bin_d;
    logic [BCD_LO_W-1:0]  lo_bcd_q, lo_bcd_d, lo_adj;
    logic [BCD_UP_W-1:0]  up_bcd_q, up_bcd_d, up_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           lower1000_d, lower0100_d, lower0010_d, lower0001_d;
    logic [7:0]           upper10_d, upper01_d;
    logic                 valid_out_d, busy_d;
    logic [OP_W-1:0]      lo_op, up_op, tim_op;
    logic [6:0]           hrs_sat;
    logic [5:0]           min_sat;
    logic [2:0]           flag_cnt;
    logic [3:0]           d3, d2, d1, d0, u1, u0;
    logic                 seconds_unused;

    // Seconds are reserved for a future display mode.
    assign seconds_unused = ^seconds;

    // Clamp a value to a decimal limit, producing a 14-bit operand.
    function automatic logic [OP_W-1:0] sat14(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? OP_W'(lim) : OP_W'(v);
    endfunction

    // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
    function automatic logic [BCD_LO_W-1:0] dabble16(input logic [BCD_LO_W-1:0] b);
        logic [BCD_LO_W-1:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BCD_UP_W-1:0] dabble8(input logic [BCD_UP_W-1:0] b);
        logic [BCD_UP_W-1:0] r;
        r = b;
        for (int i = 0; i < 2; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Selection update and saturated operand preparation for the accept edge.
    always_comb begin
        flag_cnt = 3'(AVS) + 3'(DAY) + 3'(MAX) + 3'(TIM);
        sel_new  = sel_q;
        if (flag_cnt == 3'd1) begin
            if (DAY)      sel_new = SEL_DAY;
            else if (AVS) sel_new = SEL_AVS;
            else if (MAX) sel_new = SEL_MAX;
            else          sel_new = SEL_TIM;
        end
        hrs_sat = (hours > 7'd99) ? 7'd99 : hours;
        min_sat = (minutes > 6'd59) ? 6'd59 : minutes;
        // hours*100 as (h<<6)+(h<<5)+(h<<2)
        tim_op  = (OP_W'(hrs_sat) << 6) + (OP_W'(hrs_sat) << 5) + (OP_W'(hrs_sat) << 2)
                + OP_W'(min_sat);
        case (sel_new)
            SEL_DAY: lo_op = sat14(32'(distance), 32'd9999);
            SEL_AVS: lo_op = sat14(32'(avg_speed), 32'd9999);
            SEL_MAX: lo_op = sat14(32'(max_speed), 32'd9999);
            default: lo_op = tim_op;
        endcase
        up_op = sat14(32'(speed), 32'd99);
    end

    // BCD digits and the per-cycle shift-add-3 step.
    always_comb begin
        d3     = lo_bcd_q[15:12];
        d2     = lo_bcd_q[11:8];
        d1     = lo_bcd_q[7:4];
        d0     = lo_bcd_q[3:0];
        u1     = up_bcd_q[7:4];
        u0     = up_bcd_q[3:0];
        lo_adj = dabble16(lo_bcd_q);
        up_adj = dabble8(up_bcd_q);
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lo_bin_d    = lo_bin_q;
        up_bin_d    = up_bin_q;
        lo_bcd_d    = lo_bcd_q;
        up_bcd_d    = up_bcd_q;
        cnt_d       = cnt_q;
        lower1000_d = lower1000;
        lower0100_d = lower0100;
        lower0010_d = lower0010;
        lower0001_d = lower0001;
        upper10_d   = upper10;
        upper01_d   = upper01;
        valid_out_d = 1'b0;
        busy_d      = busy;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d    = sel_new;
                    lo_bin_d = lo_op;
                    up_bin_d = up_op;
                    lo_bcd_d = '0;
                    up_bcd_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(NUM_SHIFTS)) begin
                    lower1000_d = (sel_q != SEL_TIM && d3 == 4'd0) ? ASCII_BLANK
                                                                  : ASCII_ZERO + 8'(d3);
                    lower0100_d = (sel_q != SEL_TIM && d3 == 4'd0 && d2 == 4'd0) ? ASCII_BLANK
                                                                                 : ASCII_ZERO + 8'(d2);
                    lower0010_d = ASCII_ZERO + 8'(d1);
                    lower0001_d = ASCII_ZERO + 8'(d0);
                    upper10_d   = (u1 == 4'd0) ? ASCII_BLANK : ASCII_ZERO + 8'(u1);
                    upper01_d   = ASCII_ZERO + 8'(u0);
                    valid_out_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    lo_bcd_d = BCD_LO_W'(lo_adj << 1) | BCD_LO_W'(lo_bin_q[OP_W-1]);
                    up_bcd_d = BCD_UP_W'(up_adj << 1) | BCD_UP_W'(up_bin_q[OP_W-1]);
                    lo_bin_d = OP_W'(lo_bin_q << 1);
                    up_bin_d = OP_W'(up_bin_q << 1);
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_DAY;
            lo_bin_q  <= '0;
            up_bin_q  <= '0;
            lo_bcd_q  <= '0;
            up_bcd_q  <= '0;
            cnt_q     <= '0;
            lower1000 <= ASCII_BLANK;
            lower0100 <= ASCII_BLANK;
            lower0010 <= ASCII_BLANK;
            lower0001 <= ASCII_BLANK;
            upper10   <= ASCII_BLANK;
            upper01   <= ASCII_BLANK;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lo_bin_q  <= lo_bin_d;
            up_bin_q  <= up_bin_d;
            lo_bcd_q  <= lo_bcd_d;
            up_bcd_q  <= up_bcd_d;
            cnt_q     <= cnt_d;
            lower1000 <= lower1000_d;
            lower0100 <= lower0100_d;
            lower0010 <= lower0010_d;
            lower0001 <= lower0001_d;
            upper10   <= upper10_d;
            upper01   <= upper01_d;
            valid_out <= valid_out_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_ascii_display_encoder.sv
// Directed self-checking bench for ascii_display_encoder.
module tb_ascii_display_encoder;

    logic        clock, reset, start;
    logic        AVS, DAY, MAX, TIM;
    logic [11:0] max_speed, speed, avg_speed;
    logic [13:0] distance;
    logic [6:0]  hours;
    logic [5:0]  minutes, seconds;
    logic [7:0]  lower1000, lower0100, lower0010, lower0001, upper10, upper01;
    logic        valid_out, busy;

    int n_checks = 0;
    int n_pass   = 0;

    ascii_display_encoder #(
        .SPEED_WIDTH(12), .MAX_SPEED_WIDTH(12), .AVG_SPEED_WIDTH(12)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
        .max_speed(max_speed), .speed(speed), .distance(distance),
        .avg_speed(avg_speed), .hours(hours), .minutes(minutes), .seconds(seconds),
        .lower1000(lower1000), .lower0100(lower0100), .lower0010(lower0010),
        .lower0001(lower0001), .upper10(upper10), .upper01(upper01),
        .valid_out(valid_out), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_chars(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0,
                               input logic [7:0] eu1, input logic [7:0] eu0);
        check({tag, " lower1000"}, lower1000, e3);
        check({tag, " lower0100"}, lower0100, e2);
        check({tag, " lower0010"}, lower0010, e1);
        check({tag, " lower0001"}, lower0001, e0);
        check({tag, " upper10"},   upper10,   eu1);
        check({tag, " upper01"},   upper01,   eu0);
    endtask

    task automatic set_flags(input logic a, input logic d, input logic m, input logic t);
        AVS = a; DAY = d; MAX = m; TIM = t;
    endtask

    // One conversion; optional extra start pulse (and input disturbance) mid-SHIFT.
    task automatic do_conv(input string tag, input int extra_at,
                           input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0,
                           input logic [7:0] eu1, input logic [7:0] eu0);
        int lat;
        int extra_valid;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (extra_at != 0 && lat == extra_at) begin
                start = 1'b1;
                set_flags(1'b0, 1'b1, 1'b0, 1'b0);
                avg_speed = 12'd3210;
                distance  = 14'd8888;
            end
            if (extra_at != 0 && lat == extra_at + 1) start = 1'b0;
            if (valid_out) break;
        end
        check({tag, " latency"}, 32'(lat), 32'd15);
        check_chars(tag, e3, e2, e1, e0, eu1, eu0);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        @(posedge clock); #1;
        check({tag, " valid_one_cycle"}, 32'(valid_out), 32'd0);
        if (extra_at != 0) begin
            extra_valid = 0;
            repeat (25) begin
                @(posedge clock); #1;
                if (valid_out) extra_valid++;
            end
            check({tag, " no_extra_valid"}, 32'(extra_valid), 32'd0);
        end
    endtask

    initial begin
        int stray;
        reset = 1'b0; start = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        max_speed = '0; speed = '0; avg_speed = '0; distance = '0;
        hours = '0; minutes = '0; seconds = '0;
        repeat (3) @(posedge clock);
        #1;
        check_chars("reset", 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
        check("reset valid", 32'(valid_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clock); reset = 1'b1;

        // T1: reset during a conversion aborts it
        set_flags(1'b0, 1'b1, 1'b0, 1'b0); distance = 14'd1234; speed = 12'd27;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check_chars("T1", 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
        check("T1 valid", 32'(valid_out), 32'd0);
        check("T1 busy", 32'(busy), 32'd0);
        @(negedge clock); reset = 1'b1;
        stray = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (valid_out) stray++;
        end
        check("T1 no_valid_after", 32'(stray), 32'd0);

        // No flags after reset: selection defaults to DAY
        set_flags(1'b0, 1'b0, 1'b0, 1'b0); distance = 14'd42; speed = 12'd0;
        do_conv("dflt", 0, 8'h20, 8'h20, 8'h34, 8'h32, 8'h20, 8'h30);

        // T2 / T3
        set_flags(1'b0, 1'b1, 1'b0, 1'b0); distance = 14'd1234; speed = 12'd27;
        do_conv("T2", 0, 8'h31, 8'h32, 8'h33, 8'h34, 8'h32, 8'h37);
        distance = 14'd5; speed = 12'd3;
        do_conv("T3", 0, 8'h20, 8'h20, 8'h30, 8'h35, 8'h20, 8'h33);

        // Distance and speed saturation
        distance = 14'd16383; speed = 12'd100;
        do_conv("DAYsat", 0, 8'h39, 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);

        // MAX selection, including an all-zero value
        set_flags(1'b0, 1'b0, 1'b1, 1'b0); max_speed = 12'd1000; speed = 12'd10;
        do_conv("MAX1000", 0, 8'h31, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30);
        max_speed = 12'd0; speed = 12'd0;
        do_conv("MAX0", 0, 8'h20, 8'h20, 8'h30, 8'h30, 8'h20, 8'h30);

        // T5: time mode, no blanking, hour/minute saturation
        set_flags(1'b0, 1'b0, 1'b0, 1'b1); hours = 7'd7; minutes = 6'd5;
        do_conv("T5a", 0, 8'h30, 8'h37, 8'h30, 8'h35, 8'h20, 8'h30);
        hours = 7'd120; minutes = 6'd63;
        do_conv("T5b", 0, 8'h39, 8'h39, 8'h35, 8'h39, 8'h20, 8'h30);

        // T4: 12-bit avg_speed stays below 9999; speed saturates to 99
        set_flags(1'b1, 1'b0, 1'b0, 1'b0); avg_speed = 12'd4095; speed = 12'd4095;
        do_conv("T4", 0, 8'h34, 8'h30, 8'h39, 8'h35, 8'h39, 8'h39);

        // T6: all flags high keeps AVS; mid-SHIFT start and data changes ignored
        set_flags(1'b1, 1'b1, 1'b1, 1'b1); avg_speed = 12'd250; speed = 12'd27;
        do_conv("T6", 5, 8'h20, 8'h32, 8'h35, 8'h30, 8'h32, 8'h37);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
